// File: rtl/voice_mixer.sv
// Three-voice mixer: latches voices on a strobe, accumulates them through one
// shared multiplier over three cycles, then emits a saturated 16-bit sample.
//
// state | meaning
// IDLE  | waiting for new_sample_in; latches voices, gain and mute
// MAC0  | accumulate voice 1
// MAC1  | accumulate voice 2
// MAC2  | accumulate voice 3, saturate and register the output sample
// SAT   | sample_out/sample_valid/clip presented for one cycle
module voice_mixer #(
  parameter int GAIN_SHIFT = 4,
  parameter int ACC_W      = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_sample_in,
  input  logic signed [15:0] wave1,
  input  logic signed [15:0] wave2,
  input  logic signed [15:0] wave3,
  input  logic        [4:0]  gain,
  input  logic        [2:0]  mute,
  input  logic               clr_overrun,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               clip,
  output logic               overrun,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, SAT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 15'h7fff};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'h0000};

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [15:0]       w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic        [4:0]        gain_q, gain_d;
  logic        [2:0]        mute_q, mute_d;
  logic signed [15:0]       sample_out_q, sample_out_d;
  logic                     valid_q, valid_d;
  logic                     clip_q, clip_d;
  logic                     overrun_q, overrun_d;

  logic signed [15:0]       mul_wave;
  logic                     mul_mute;
  logic signed [20:0]       mul_a, mul_b, prod;
  logic signed [ACC_W-1:0]  acc_sum, sat_t;
  logic signed [15:0]       sat_val;
  logic                     sat_clip;

  // One multiplier, operand selected by the MAC phase.
  always_comb begin
    mul_wave = w1_q;
    mul_mute = mute_q[0];
    case (state_q)
      MAC1: begin
        mul_wave = w2_q;
        mul_mute = mute_q[1];
      end
      MAC2: begin
        mul_wave = w3_q;
        mul_mute = mute_q[2];
      end
      default: ;
    endcase
    mul_a   = {{5{mul_wave[15]}}, mul_wave};
    mul_b   = {16'b0, gain_q};
    prod    = mul_mute ? 21'sd0 : mul_a * mul_b;
    acc_sum = acc_q + {{(ACC_W-21){prod[20]}}, prod};
    sat_t   = acc_sum >>> GAIN_SHIFT;
    if (sat_t > SAT_MAX) begin
      sat_val  = 16'sh7fff;
      sat_clip = 1'b1;
    end else if (sat_t < SAT_MIN) begin
      sat_val  = 16'sh8000;
      sat_clip = 1'b1;
    end else begin
      sat_val  = sat_t[15:0];
      sat_clip = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    gain_d       = gain_q;
    mute_d       = mute_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    clip_d       = 1'b0;
    overrun_d    = overrun_q;

    if (clr_overrun)
      overrun_d = 1'b0;
    if (new_sample_in && state_q != IDLE)
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (new_sample_in) begin
          w1_d    = wave1;
          w2_d    = wave2;
          w3_d    = wave3;
          gain_d  = gain;
          mute_d  = mute;
          acc_d   = '0;
          state_d = MAC0;
        end
      end
      MAC0: begin
        acc_d   = acc_sum;
        state_d = MAC1;
      end
      MAC1: begin
        acc_d   = acc_sum;
        state_d = MAC2;
      end
      // Final sum is saturated here so the sample is visible during SAT.
      MAC2: begin
        acc_d        = acc_sum;
        sample_out_d = sat_val;
        valid_d      = 1'b1;
        clip_d       = sat_clip;
        state_d      = SAT;
      end
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      gain_q       <= '0;
      mute_q       <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      gain_q       <= gain_d;
      mute_q       <= mute_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: hand-computed mixes, saturation, overrun
// handling and mid-operation reset.
module tb_voice_mixer;

  logic               clk;
  logic               reset_n;
  logic               new_sample_in;
  logic signed [15:0] wave1, wave2, wave3;
  logic        [4:0]  gain;
  logic        [2:0]  mute;
  logic               clr_overrun;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               clip;
  logic               overrun;
  logic               busy;

  int vectors;
  int miscompares;

  voice_mixer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .new_sample_in (new_sample_in),
    .wave1         (wave1),
    .wave2         (wave2),
    .wave3         (wave3),
    .gain          (gain),
    .mute          (mute),
    .clr_overrun   (clr_overrun),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .clip          (clip),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe one sample, scramble the inputs, and wait (bounded) for sample_valid.
  // lat counts cycles from the strobe to sample_valid; -1 means it never came.
  task automatic mix(input logic signed [15:0] a, input logic signed [15:0] b,
                     input logic signed [15:0] c, input logic [4:0] g,
                     input logic [2:0] m, output logic signed [15:0] out,
                     output logic clp, output int lat);
    @(negedge clk);
    wave1 = a; wave2 = b; wave3 = c; gain = g; mute = m;
    new_sample_in = 1'b1;
    @(negedge clk);
    new_sample_in = 1'b0;
    wave1 = ~a; wave2 = ~b; wave3 = ~c; gain = ~g; mute = ~m;
    lat = -1; out = '0; clp = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (sample_valid) begin
        lat = i; out = sample_out; clp = clip;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; new_sample_in = 1'b0; clr_overrun = 1'b0;
    wave1 = '0; wave2 = '0; wave3 = '0; gain = '0; mute = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sample_out, sample_valid, clip, overrun, busy} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out=%0d v=%b c=%b o=%b b=%b, want all 0",
               sample_out, sample_valid, clip, overrun, busy);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b valid=%b, want 0/0", busy, sample_valid);
    end
  endtask

  task automatic test_unity();
    logic signed [15:0] out; logic clp; int lat;
    mix(16'sd1000, 16'sd2000, 16'sd3000, 5'd16, 3'b000, out, clp, lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL unity_latency: got %0d cycles, want 4", lat);
    end
    vectors++;
    if (out !== 16'sd6000 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL unity_value: got %0d clip=%b, want 6000 clip=0", out, clp);
    end
    @(negedge clk);
    vectors++;
    if (sample_valid !== 1'b0 || busy !== 1'b0 || sample_out !== 16'sd6000) begin
      miscompares++;
      $display("FAIL unity_after: got valid=%b busy=%b out=%0d, want 0 0 6000",
               sample_valid, busy, sample_out);
    end
  endtask

  task automatic test_saturate();
    logic signed [15:0] out; logic clp; int lat;
    mix(16'sd30000, 16'sd30000, 16'sd30000, 5'd31, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd32767 || clp !== 1'b1 || lat !== 4) begin
      miscompares++;
      $display("FAIL sat_pos: got %0d clip=%b lat=%0d, want 32767 clip=1 lat=4", out, clp, lat);
    end
    mix(-16'sd30000, -16'sd30000, -16'sd30000, 5'd31, 3'b000, out, clp, lat);
    vectors++;
    if (out !== -16'sd32768 || clp !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_neg: got %0d clip=%b, want -32768 clip=1", out, clp);
    end
    @(negedge clk);
    vectors++;
    if (clip !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_pulse: got clip=%b after SAT, want 0", clip);
    end
    mix(16'sd32767, 16'sd0, 16'sd0, 5'd16, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd32767 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_max: got %0d clip=%b, want 32767 clip=0", out, clp);
    end
    mix(-16'sd32768, 16'sd0, 16'sd0, 5'd16, 3'b000, out, clp, lat);
    vectors++;
    if (out !== -16'sd32768 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_min: got %0d clip=%b, want -32768 clip=0", out, clp);
    end
    mix(16'sd32767, 16'sd1, 16'sd0, 5'd16, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd32767 || clp !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_over: got %0d clip=%b, want 32767 clip=1", out, clp);
    end
  endtask

  task automatic test_floor_gain0();
    logic signed [15:0] out; logic clp; int lat;
    mix(-16'sd1, 16'sd0, 16'sd0, 5'd1, 3'b000, out, clp, lat);
    vectors++;
    if (out !== -16'sd1 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL floor_m1: got %0d clip=%b, want -1 clip=0", out, clp);
    end
    mix(-16'sd5, 16'sd0, 16'sd0, 5'd3, 3'b000, out, clp, lat);
    vectors++;
    if (out !== -16'sd1) begin
      miscompares++;
      $display("FAIL floor_m15: got %0d, want -1", out);
    end
    mix(16'sd5, 16'sd0, 16'sd0, 5'd3, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd0) begin
      miscompares++;
      $display("FAIL floor_p15: got %0d, want 0", out);
    end
    mix(16'sd12345, -16'sd32768, 16'sd32767, 5'd0, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd0 || clp !== 1'b0 || lat !== 4) begin
      miscompares++;
      $display("FAIL gain_zero: got %0d clip=%b lat=%0d, want 0 clip=0 lat=4", out, clp, lat);
    end
    mix(16'sd5000, 16'sd5000, 16'sd5000, 5'd16, 3'b111, out, clp, lat);
    vectors++;
    if (out !== 16'sd0 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL mute_all: got %0d clip=%b, want 0 clip=0", out, clp);
    end
  endtask

  task automatic test_mute();
    logic signed [15:0] out; logic clp; int lat;
    mix(16'sd100, 16'sd5000, 16'sd200, 5'd16, 3'b010, out, clp, lat);
    vectors++;
    if (out !== 16'sd300 || clp !== 1'b0) begin
      miscompares++;
      $display("FAIL mute_v2: got %0d clip=%b, want 300 clip=0", out, clp);
    end
    mix(16'sd100, 16'sd5000, 16'sd200, 5'd16, 3'b101, out, clp, lat);
    vectors++;
    if (out !== 16'sd5000) begin
      miscompares++;
      $display("FAIL mute_v13: got %0d, want 5000", out);
    end
  endtask

  task automatic test_overrun();
    int seen;
    @(negedge clk);  // cycle N
    wave1 = 16'sd1000; wave2 = 16'sd2000; wave3 = 16'sd3000; gain = 5'd16; mute = 3'b000;
    new_sample_in = 1'b1;
    @(negedge clk);  // N+1
    new_sample_in = 1'b0;
    wave1 = 16'sd7; wave2 = 16'sd7; wave3 = 16'sd7; gain = 5'd31; mute = 3'b111;
    vectors++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_busy: got busy=%b overrun=%b, want 1/0", busy, overrun);
    end
    @(negedge clk);  // N+2
    new_sample_in = 1'b1;
    wave1 = 16'sd1; wave2 = 16'sd1; wave3 = 16'sd1; gain = 5'd16; mute = 3'b000;
    @(negedge clk);  // N+3
    new_sample_in = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_set: got overrun=%b valid=%b, want 1/0", overrun, sample_valid);
    end
    @(negedge clk);  // N+4 (SAT): strobe here is dropped, and set beats clear
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 16'sd6000) begin
      miscompares++;
      $display("FAIL ovr_result: got valid=%b out=%0d, want 1 6000", sample_valid, sample_out);
    end
    new_sample_in = 1'b1; clr_overrun = 1'b1;
    @(negedge clk);  // N+5
    new_sample_in = 1'b0; clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_sat_drop: got overrun=%b busy=%b valid=%b, want 1 0 0",
               overrun, busy, sample_valid);
    end
    wave1 = 16'sd10; wave2 = 16'sd20; wave3 = 16'sd30; gain = 5'd16; mute = 3'b000;
    new_sample_in = 1'b1; clr_overrun = 1'b1;
    @(negedge clk);  // N+6
    new_sample_in = 1'b0; clr_overrun = 1'b0;
    wave1 = 16'sd0; wave2 = 16'sd0; wave3 = 16'sd0;
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_clear: got overrun=%b busy=%b, want 0/1", overrun, busy);
    end
    seen = -1;
    for (int i = 1; i <= 10; i++) begin
      if (sample_valid) begin
        seen = i;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (seen !== 4 || sample_out !== 16'sd60) begin
      miscompares++;
      $display("FAIL ovr_accept: got lat=%0d out=%0d, want lat=4 out=60", seen, sample_out);
    end
  endtask

  task automatic test_reset_midop();
    logic signed [15:0] out; logic clp; int lat; int seen;
    @(negedge clk);  // cycle N
    wave1 = 16'sd1000; wave2 = 16'sd1000; wave3 = 16'sd1000; gain = 5'd16; mute = 3'b000;
    new_sample_in = 1'b1;
    @(negedge clk);  // N+1
    new_sample_in = 1'b0;
    @(negedge clk);  // N+2
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({sample_out, sample_valid, clip, overrun, busy} !== 20'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got out=%0d v=%b c=%b o=%b b=%b, want all 0",
               sample_out, sample_valid, clip, overrun, busy);
    end
    seen = 0;
    for (int i = 3; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) reset_n = 1'b1;
      if (sample_valid) seen++;
    end
    vectors++;
    if (seen !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_novalid: got %0d valid pulses busy=%b, want 0 busy=0", seen, busy);
    end
    mix(16'sd1000, 16'sd2000, 16'sd3000, 5'd16, 3'b000, out, clp, lat);
    vectors++;
    if (out !== 16'sd6000 || clp !== 1'b0 || lat !== 4) begin
      miscompares++;
      $display("FAIL midreset_recover: got %0d clip=%b lat=%0d, want 6000 clip=0 lat=4",
               out, clp, lat);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_unity();
    test_saturate();
    test_floor_gain0();
    test_mute();
    test_overrun();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
